keycode_event_fifo: RTL and testbench
=====================================

# keycode_event_fifo

Converts USB HID boot-protocol keycode snapshots into a stream of discrete press and release events, buffered in a FIFO. It sits between the keycode PIO export of the SoC and consumer logic such as game or text-entry FSMs. It generalises the single 8-bit keycode export to N simultaneous key slots with parametrised code width and buffer depth, and adds edge detection, rollover rejection and overflow reporting.

## Interface
- N_KEYS, 6, number of key slots per report (2..8)
- CODE_W, 8, keycode width in bits
- DEPTH, 16, FIFO depth in events (power of 2, ≥2)

- clk_clk  in  1  system clock
- reset_reset_n  in  1  reset, asynchronous, active-low
- keycode_in  in  N_KEYS*CODE_W  report; slot i = bits [i*CODE_W +: CODE_W], code 0 = empty slot
- keycode_valid  in  1  one-cycle strobe, keycode_in holds a new report
- evt_data  out  CODE_W+1  FIFO head; MSB 1 = press, 0 = release; low bits = code
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready
- evt_count  out  $clog2(DEPTH)+1  events currently stored
- busy  out  1  scan in progress or report pending
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- clear_overflow  in  1  clears overflow

There is one clock, clk_clk. Reset reset_reset_n is asynchronous and active-low.

## Operation
- Registers:
  - prev report (N_KEYS codes, reset all 0)
  - cur report
  - one-deep pending slot plus pending_valid
- States: IDLE, SCAN_PRESS, SCAN_REL, COMMIT. Slot index idx runs 0..N_KEYS-1.
- Report capture:
  - keycode_valid in IDLE with no pending: load cur and go to SCAN_PRESS with idx=0.
  - keycode_valid in any other state: write the pending slot. The newest report overwrites an unprocessed one.
- Rollover: if any slot of a report equals 1 (ErrorRollOver), the report is discarded at capture. Pending is not written. No events are produced and prev is unchanged.
- SCAN_PRESS, one slot per cycle:
  - Emit press for cur[idx] if it is nonzero, not present in any prev slot, and not equal to any cur[j] with j<idx (duplicates emit once).
  - After idx=N_KEYS-1, go to SCAN_REL with idx=0.
- SCAN_REL: the same test with the roles of prev and cur swapped, emitting release. After the last slot, go to COMMIT.
- COMMIT: prev <= cur. Then:
  - If pending_valid, load cur from pending, clear pending_valid and go to SCAN_PRESS.
  - Otherwise go to IDLE.
- FIFO behaviour:
  - First-word-fall-through; evt_data is valid whenever evt_valid=1.
  - A push is accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the event is dropped and overflow is set. The scan does not stall.
- overflow control: clear_overflow clears it. If a drop and clear_overflow occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH. evt_count spans 0..DEPTH.
- Slot order is preserved: all presses precede all releases within one report, each group in ascending idx.

## Timing
- Reset values:
  - evt_valid=0, evt_count=0, busy=0, overflow=0
  - evt_data=0, state IDLE, prev all 0, pending_valid=0
- Reset mid-scan: all state above is restored immediately. Partial events already pushed are lost.
- Report strobed at edge T: SCAN_PRESS idx=0 is active in cycle T+1.
- The press test for slot i runs in cycle T+1+i. The release test for slot i runs in cycle T+1+N_KEYS+i.
- COMMIT occurs in cycle T+1+2*N_KEYS. Total scan length is 2*N_KEYS+1 cycles.
- An event pushed in cycle c gives evt_valid=1 and updated evt_count from cycle c+1.
- busy is registered: it is 1 from cycle T+1 until the COMMIT that finds no pending report, and 0 the cycle after that COMMIT.
- A pop in cycle c advances the head at edge c. A simultaneous push and pop leaves evt_count unchanged.

## Test plan
- Single press: report {0x04,0,0,0,0,0} from idle → exactly one event 0x104 (press, 'A'), evt_valid rising 2 cycles after the strobe, busy high for 13 cycles.
- Release and overlap:
  - Report {0x04} then {0x05} → 0x104, then 0x105 followed by 0x004.
  - Then an all-zero report → 0x005.
- Rollover and duplicates:
  - Report {0x01,0x04,...} → no events and prev unchanged.
  - Report {0x07,0x07,0,...} → a single 0x107.
- Pending overwrite: three strobes 1 cycle apart ({0x04},{0x05},{0x06}) → the scan of 0x04 completes. The second report is replaced by the third. Events are 0x104 then 0x106, 0x004; no 0x105.
- Overflow with DEPTH=2 and evt_ready=0: report {0x04,0x05,0x06} → evt_count=2, overflow=1, head 0x104. Asserting clear_overflow for one cycle → overflow=0.
- Reset mid-scan: assert reset_reset_n=0 during cycle T+3 → evt_valid=0, busy=0, evt_count=0 immediately. The same report after reset re-emits all presses.

Source files
------------

// File: rtl/keycode_event_fifo_if.sv
// rtl/keycode_event_fifo_if.sv - event stream interface between keycode_event_fifo and its consumer
//
// evt_data  : FIFO head, MSB 1 = press / 0 = release, low CODE_W bits = keycode
// evt_valid : FIFO non-empty, evt_data is meaningful
// evt_ready : consumer pop; a pop happens when evt_valid && evt_ready
// master = event producer (the FIFO), slave = event consumer.

interface keycode_event_fifo_if #(
    parameter int CODE_W = 8
);
    logic [CODE_W:0] evt_data;
    logic            evt_valid;
    logic            evt_ready;

    modport master (
        output evt_data,
        output evt_valid,
        input  evt_ready
    );

    modport slave (
        input  evt_data,
        input  evt_valid,
        output evt_ready
    );
endinterface

// File: rtl/keycode_event_fifo.sv
// rtl/keycode_event_fifo.sv - HID keycode snapshots to press/release events, FIFO buffered
//
// Ports:
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   keycode_in             : N_KEYS slots of CODE_W bits, slot i at [i*CODE_W +: CODE_W], 0 = empty
//   keycode_valid          : one-cycle strobe, keycode_in holds a new report
//   evt (master)           : first-word-fall-through event stream (evt_data/evt_valid/evt_ready)
//   evt_count              : events currently stored, 0..DEPTH
//   busy                   : scan in progress or report pending
//   overflow               : sticky, an event was dropped on a full FIFO
//   clear_overflow         : clears overflow (a same-cycle drop wins)

module keycode_event_fifo #(
    parameter int N_KEYS = 6,
    parameter int CODE_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [N_KEYS*CODE_W-1:0]   keycode_in,
    input  logic                       keycode_valid,
    keycode_event_fifo_if.master       evt,
    output logic [$clog2(DEPTH):0]     evt_count,
    output logic                       busy,
    output logic                       overflow,
    input  logic                       clear_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

    typedef logic [CODE_W-1:0] code_t;
    typedef enum logic [1:0] {IDLE, SCAN_PRESS, SCAN_REL, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    code_t           prev_q [N_KEYS];
    code_t           prev_d [N_KEYS];
    code_t           cur_q  [N_KEYS];
    code_t           cur_d  [N_KEYS];
    code_t           pend_q [N_KEYS];
    code_t           pend_d [N_KEYS];
    logic            pend_valid_q, pend_valid_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;

    logic [CODE_W:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;

    code_t           in_codes [N_KEYS];
    logic            rollover;
    logic            report_ok;

    // scan_a is the report being tested, scan_b the one it is compared against
    code_t           scan_a [N_KEYS];
    code_t           scan_b [N_KEYS];
    code_t           scan_code;
    logic            scanning;
    logic            push_req;
    logic [CODE_W:0] push_data;

    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;

    // Report unpack and ErrorRollOver (code 1) detection
    always_comb begin
        rollover = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            in_codes[i] = keycode_in[i*CODE_W +: CODE_W];
            if (in_codes[i] == code_t'(1)) begin
                rollover = 1'b1;
            end
        end
    end

    assign report_ok = keycode_valid && !rollover;

    // Edge test: the slot code is new if nonzero, absent from the other report,
    // and not a repeat of an earlier slot of the same report.
    always_comb begin
        for (int j = 0; j < N_KEYS; j++) begin
            scan_a[j] = (state_q == SCAN_PRESS) ? cur_q[j]  : prev_q[j];
            scan_b[j] = (state_q == SCAN_PRESS) ? prev_q[j] : cur_q[j];
        end
        scanning  = (state_q == SCAN_PRESS) || (state_q == SCAN_REL);
        scan_code = scan_a[idx_q];
        push_req  = scanning && (scan_code != '0);
        for (int j = 0; j < N_KEYS; j++) begin
            if (scan_b[j] == scan_code) begin
                push_req = 1'b0;
            end
            if ((IW'(j) < idx_q) && (scan_a[j] == scan_code)) begin
                push_req = 1'b0;
            end
        end
        push_data = {(state_q == SCAN_PRESS), scan_code};
    end

    // Scan FSM
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        prev_d       = prev_q;
        cur_d        = cur_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        case (state_q)
            IDLE: begin
                if (report_ok) begin
                    cur_d        = in_codes;
                    pend_valid_d = 1'b0;
                    state_d      = SCAN_PRESS;
                    idx_d        = '0;
                end else if (pend_valid_q) begin
                    // A report that landed during the final COMMIT cycle
                    cur_d        = pend_q;
                    pend_valid_d = 1'b0;
                    state_d      = SCAN_PRESS;
                    idx_d        = '0;
                end
            end
            SCAN_PRESS: begin
                if (idx_q == IW'(N_KEYS - 1)) begin
                    state_d = SCAN_REL;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            SCAN_REL: begin
                if (idx_q == IW'(N_KEYS - 1)) begin
                    state_d = COMMIT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            COMMIT: begin
                prev_d = cur_q;
                if (pend_valid_q) begin
                    cur_d        = pend_q;
                    pend_valid_d = 1'b0;
                    state_d      = SCAN_PRESS;
                    idx_d        = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A report arriving while busy goes to the pending slot; placed after
        // the case so it wins over COMMIT consuming the previous pending report.
        if (report_ok && (state_q != IDLE)) begin
            pend_d       = in_codes;
            pend_valid_d = 1'b1;
        end

        busy_d = (state_d != IDLE) || pend_valid_d;
    end

    // FIFO control; a full FIFO still accepts when the head pops this cycle
    always_comb begin
        pop      = (count_q != '0) && evt.evt_ready;
        full     = (count_q == (AW+1)'(DEPTH));
        push_ok  = push_req && (!full || pop);
        drop     = push_req && !push_ok;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pend_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                prev_q[i] <= '0;
                cur_q[i]  <= '0;
                pend_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            prev_q       <= prev_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign evt_count     = count_q;
    assign busy          = busy_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_keycode_event_fifo.sv
// tb/tb_keycode_event_fifo.sv - directed bench for keycode_event_fifo

module tb_keycode_event_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] kc = '0;
    logic        kv = 1'b0;
    logic        clr = 1'b0;
    logic        ready1 = 1'b1;

    logic [4:0]  cnt1;
    logic        busy1, ovf1;
    logic [1:0]  cnt2;
    logic        busy2, ovf2;

    int          checks = 0;
    int          failures = 0;
    logic [8:0]  evq[$];
    int          n;

    always #5 clk = ~clk;

    keycode_event_fifo_if #(.CODE_W(8)) evt_if ();
    keycode_event_fifo_if #(.CODE_W(8)) evt2_if ();

    assign evt_if.evt_ready  = ready1;
    assign evt2_if.evt_ready = 1'b0;

    keycode_event_fifo #(.N_KEYS(6), .CODE_W(8), .DEPTH(16)) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .keycode_in     (kc),
        .keycode_valid  (kv),
        .evt            (evt_if),
        .evt_count      (cnt1),
        .busy           (busy1),
        .overflow       (ovf1),
        .clear_overflow (clr)
    );

    keycode_event_fifo #(.N_KEYS(6), .CODE_W(8), .DEPTH(2)) dut2 (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .keycode_in     (kc),
        .keycode_valid  (kv),
        .evt            (evt2_if),
        .evt_count      (cnt2),
        .busy           (busy2),
        .overflow       (ovf2),
        .clear_overflow (clr)
    );

    // Record every event the consumer pops from the main instance
    always @(negedge clk) begin
        if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            evq.push_back(evt_if.evt_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] rpt(input logic [7:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [47:0] r);
        kc = r;
        kv = 1'b1;
        tick();
        kv = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy1 && cycles < 100) begin
            cycles++;
            tick();
        end
        check("idle_timeout", busy1, 0);
        repeat (4) tick();
    endtask

    task automatic check_q(input string tag, input int cnt,
                           input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
        logic [8:0] ex[3];
        ex = '{e0, e1, e2};
        check({tag, "_n"}, evq.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < evq.size()) begin
                check($sformatf("%s_%0d", tag, i), evq[i], ex[i]);
            end
        end
        evq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        evq.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", evt_if.evt_valid, 0);
        check("rst_count", cnt1, 0);
        check("rst_busy", busy1, 0);
        check("rst_ovf", ovf1, 0);
        check("rst_data", evt_if.evt_data, 0);
        rst_n = 1'b1;
        tick();

        // Single press, latency and busy length
        send(rpt(8'h04, 0, 0, 0, 0, 0));
        check("t1_valid_t1", evt_if.evt_valid, 0);
        check("t1_busy_t1", busy1, 1);
        tick();
        check("t1_valid_t2", evt_if.evt_valid, 1);
        check("t1_data_t2", evt_if.evt_data, 9'h104);
        check("t1_count_t2", cnt1, 1);
        wait_idle(n);
        check("t1_busy_len", n + 1, 13);
        check_q("t1_ev", 1, 9'h104, 0, 0);

        // Overlap: new key pressed before old one released
        send(rpt(8'h05, 0, 0, 0, 0, 0));
        wait_idle(n);
        check_q("t2_ev", 2, 9'h105, 9'h004, 0);
        send(rpt(0, 0, 0, 0, 0, 0));
        wait_idle(n);
        check_q("t2z_ev", 1, 9'h005, 0, 0);

        // Duplicates emit once, rollover report ignored with prev kept
        send(rpt(8'h07, 8'h07, 0, 0, 0, 0));
        wait_idle(n);
        check_q("t3dup_ev", 1, 9'h107, 0, 0);
        send(rpt(8'h01, 8'h04, 0, 0, 0, 0));
        check("t3_roll_busy", busy1, 0);
        wait_idle(n);
        check_q("t3roll_ev", 0, 0, 0, 0);
        send(rpt(8'h07, 0, 0, 0, 0, 0));
        wait_idle(n);
        check_q("t3prev_ev", 0, 0, 0, 0);
        send(rpt(0, 0, 0, 0, 0, 0));
        wait_idle(n);
        check_q("t3clr_ev", 1, 9'h007, 0, 0);

        // Pending overwrite: three back-to-back reports
        kc = rpt(8'h04, 0, 0, 0, 0, 0);
        kv = 1'b1;
        tick();
        kc = rpt(8'h05, 0, 0, 0, 0, 0);
        tick();
        kc = rpt(8'h06, 0, 0, 0, 0, 0);
        tick();
        kv = 1'b0;
        wait_idle(n);
        check_q("t4_ev", 3, 9'h104, 9'h106, 9'h004);

        // Overflow on the 2-deep instance (never popped)
        do_reset();
        send(rpt(8'h04, 8'h05, 8'h06, 0, 0, 0));
        wait_idle(n);
        check("t5_cnt2", cnt2, 2);
        check("t5_ovf2", ovf2, 1);
        check("t5_head2", evt2_if.evt_data, 9'h104);
        check("t5_valid2", evt2_if.evt_valid, 1);
        check("t5_ovf1", ovf1, 0);
        check_q("t5_ev", 3, 9'h104, 9'h105, 9'h106);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_ovf2_clr", ovf2, 0);
        check("t5_cnt2_kept", cnt2, 2);

        // Reset in cycle T+3 of a scan
        send(rpt(8'h08, 8'h09, 0, 0, 0, 0));
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_valid", evt_if.evt_valid, 0);
        check("t6_busy", busy1, 0);
        check("t6_count", cnt1, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        evq.delete();
        send(rpt(8'h08, 8'h09, 0, 0, 0, 0));
        wait_idle(n);
        check_q("t6_ev", 2, 9'h108, 9'h109, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
